// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: denormalizer FSM states, request bundle, constants.
package fp32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    MUL_Z,
    DONE
  } denorm3_state_t;

  // Operands latched on accept and held for the three multiply cycles
  typedef struct packed {
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
    logic [31:0] len;
  } denorm3_req_t;

  localparam logic [31:0] FP32_MAX_POS = 32'h7F7FFFFF;
  localparam logic [31:0] FP32_MAX_NEG = 32'hFF7FFFFF;
  localparam logic [31:0] FP32_ONE     = 32'h3F800000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

endpackage

// File: rtl/fp32_mul.sv
// Combinational FP32 multiply: round-to-nearest-even, subnormal inputs and
// results flushed to signed zero, overflow returns signed Inf and raises
// overflow, NaN or Inf*0 returns the canonical quiet NaN.
module fp32_mul
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        overflow
);

  logic               sgn;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]        prod;
  logic [22:0]        mant;
  logic               guard, sticky;
  logic [23:0]        mant_r;
  logic signed [10:0] exp_n;

  assign sgn    = a[31] ^ b[31];
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign prod   = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};

  // Normalize the 1.x * 1.y product, round, then resolve special cases
  always_comb begin
    exp_n = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_n + 11'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    mant_r = {1'b0, mant} + {23'h0, guard & (sticky | mant[0])};
    // rounding carried out of the fraction: fraction is now zero, bump exponent
    if (mant_r[23]) exp_n = exp_n + 11'sd1;
    y        = {sgn, exp_n[7:0], mant_r[22:0]};
    overflow = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      y = FP32_QNAN;
    else if (a_inf || b_inf)
      y = {sgn, 8'hFF, 23'h0};
    else if (a_zero || b_zero)
      y = {sgn, 31'h0};
    else if (exp_n >= 11'sd255) begin
      y        = {sgn, 8'hFF, 23'h0};
      overflow = 1'b1;
    end else if (exp_n <= 11'sd0)
      y = {sgn, 31'h0};
  end

endmodule

// File: rtl/fp32_denormalize3.sv
// v = len * d for a 3-component FP32 vector, one shared multiplier walked
// over x, y, z by a small FSM with valid/ready on both sides.
// Optional build macro FP32_DENORM3_SAT_EN: overflowing components are
// clamped to +/-FP32 max instead of Inf (out_ovf is reported either way).
module fp32_denormalize3
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dx,
  input  logic [31:0] dy,
  input  logic [31:0] dz,
  input  logic [31:0] len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ox,
  output logic [31:0] oy,
  output logic [31:0] oz,
  output logic        out_ovf
);

  denorm3_state_t state, state_nxt;
  denorm3_req_t   req_q;
  logic           accept;
  logic [31:0]    mul_a, mul_y, prod;
  logic           mul_ovf;

  fp32_mul u_mul (
    .a        (mul_a),
    .b        (req_q.len),
    .y        (mul_y),
    .overflow (mul_ovf)
  );

`ifdef FP32_DENORM3_SAT_EN
  assign prod = mul_ovf ? (mul_y[31] ? FP32_MAX_NEG : FP32_MAX_POS) : mul_y;
`else
  assign prod = mul_y;
`endif

  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Next state, input readiness and multiplier operand select
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_a     = req_q.dx;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL_X;
      end
      MUL_X: begin
        mul_a     = req_q.dx;
        state_nxt = MUL_Y;
      end
      MUL_Y: begin
        mul_a     = req_q.dy;
        state_nxt = MUL_Z;
      end
      MUL_Z: begin
        mul_a     = req_q.dz;
        state_nxt = DONE;
      end
      DONE: begin
        // releasing the result and taking a new input can share one edge
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? MUL_X : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand latch and per-component result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      ox      <= '0;
      oy      <= '0;
      oz      <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q   <= {dx, dy, dz, len};
        out_ovf <= 1'b0;
      end
      case (state)
        MUL_X: begin
          ox      <= prod;
          out_ovf <= out_ovf | mul_ovf;
        end
        MUL_Y: begin
          oy      <= prod;
          out_ovf <= out_ovf | mul_ovf;
        end
        MUL_Z: begin
          oz      <= prod;
          out_ovf <= out_ovf | mul_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_denormalize3.sv
// Directed bench for fp32_denormalize3. A real-arithmetic reference model
// predicts every result; a negedge monitor compares whenever out_valid is
// high, and directed steps pin literal values, latency and handshakes.
module tb_fp32_denormalize3;
  import fp32_pkg::*;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [31:0] dx, dy, dz, len, ox, oy, oz;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [31:0] x, y, z;
    logic        ovf;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

`ifdef FP32_DENORM3_SAT_EN
  localparam logic [31:0] OVF_X = 32'h7F7FFFFF;
`else
  localparam logic [31:0] OVF_X = 32'h7F800000;
`endif

  fp32_denormalize3 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dx(dx), .dy(dy), .dz(dz), .len(len),
    .out_valid(out_valid), .out_ready(out_ready),
    .ox(ox), .oy(oy), .oz(oz), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Exact product in double precision, then rounded to FP32 by hand
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          output logic ovf);
    logic        s;
    logic [10:0] ea, eb;
    logic [63:0] pb;
    logic [23:0] keep;
    logic [28:0] rem;
    real         p;
    int          e;
    ovf = 1'b0;
    s   = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h7FC00000;
    if ((a[30:23] == 8'hFF && b[30:23] == 8'h00) || (b[30:23] == 8'hFF && a[30:23] == 8'h00))
      return 32'h7FC00000;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    ea = {3'b000, a[30:23]} + 11'd896;
    eb = {3'b000, b[30:23]} + 11'd896;
    p  = $bitstoreal({1'b0, ea, a[22:0], 29'h0}) * $bitstoreal({1'b0, eb, b[22:0], 29'h0});
    pb = $realtobits(p);
    e    = int'(pb[62:52]) - 1023 + 127;
    keep = {1'b0, pb[51:29]};
    rem  = pb[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && keep[0])) keep = keep + 24'd1;
    if (keep[23]) begin
      e    = e + 1;
      keep = 24'h0;
    end
    if (e >= 255) begin
      ovf = 1'b1;
      return {s, 8'hFF, 23'h0};
    end
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] comp_mul(input logic [31:0] a, input logic [31:0] b,
                                           output logic ovf);
    logic [31:0] r;
    r = ref_mul(a, b, ovf);
`ifdef FP32_DENORM3_SAT_EN
    if (ovf) r = r[31] ? 32'hFF7FFFFF : 32'h7F7FFFFF;
`endif
    return r;
  endfunction

  // Monitor: compare held results against the model, then record new accepts
  initial begin
    exp_t e;
    logic o1, o2, o3, head_seen;
    head_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        head_seen = 1'b0;
      end else begin
        if (out_valid) begin
          chk("pending_result", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("model_ox", ox, e.x);
            chk("model_oy", oy, e.y);
            chk("model_oz", oz, e.z);
            chk("model_ovf", 32'(out_ovf), 32'(e.ovf));
            if (!head_seen) begin
              chk("model_latency", 32'(cyc), 32'(e.cyc + 3));
              head_seen = 1'b1;
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              head_seen = 1'b0;
            end
          end
        end
        if (in_valid && in_ready) begin
          e.x   = comp_mul(dx, len, o1);
          e.y   = comp_mul(dy, len, o2);
          e.z   = comp_mul(dz, len, o3);
          e.ovf = o1 | o2 | o3;
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [31:0] l);
    int n = 0;
    dx = x; dy = y; dz = z; len = l; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called one edge after accept; edges until out_valid should be 3
  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd3);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z, input logic ovf);
    chk({nm, "_ox"}, ox, x);
    chk({nm, "_oy"}, oy, y);
    chk({nm, "_oz"}, oz, z);
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  logic [31:0] rv_a[8]   = '{32'h3FC00000, 32'h3F800001, 32'h3F800005, 32'h3F800003,
                             32'h3FFFFFFF, 32'h7F800000, 32'h7F800000, 32'h00800000};
  logic [31:0] rv_b[8]   = '{32'h3FC00000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000,
                             32'h3FFFFFFF, 32'h00000000, 32'hBF800000, 32'h3F000000};
  logic [31:0] rv_exp[8] = '{32'h40100000, 32'h3F800002, 32'h3FC00008, 32'h3FC00004,
                             32'h407FFFFE, 32'h7FC00000, 32'hFF800000, 32'h00000000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dx = '0; dy = '0; dz = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    expect_out("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // basic
    send(32'h3F000000, 32'hBF000000, 32'h3E800000, 32'h40800000);
    wait_out();
    expect_out("basic", 32'h40000000, 32'hC0000000, 32'h3F800000, 1'b0);

    // backpressure: hold result 5 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h3F000000, 32'hBF000000, 32'h3E800000, 32'h40000000);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      expect_out("bp", 32'h3F800000, 32'hBF800000, 32'h3F000000, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_drop_valid", 32'(out_valid), 32'd0);

    // back-to-back: three low cycles between valid pulses, in_ready only in DONE
    dx = FP32_ONE; dy = '0; dz = '0; len = 32'h40000000; in_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) len = 32'h40400000;
      chk("b2b_valid", 32'(out_valid), 32'(c == 4 || c == 8));
      chk("b2b_in_ready", 32'(in_ready), 32'(c == 4 || c == 8));
      if (c == 4) chk("b2b_ox0", ox, 32'h40000000);
      if (c == 8) begin
        chk("b2b_ox1", ox, 32'h40400000);
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;

    // overflow
    send(32'h40000000, 32'h0, 32'h0, 32'h7F000000);
    wait_out();
    expect_out("ovf", OVF_X, 32'h0, 32'h0, 1'b1);

    // zero length and negative length
    send(FP32_ONE, 32'hBF800000, 32'h0, 32'h00000000);
    wait_out();
    expect_out("zero", 32'h0, 32'h80000000, 32'h0, 1'b0);
    send(FP32_ONE, 32'h0, 32'h0, 32'hBF800000);
    wait_out();
    expect_out("neg", 32'hBF800000, 32'h80000000, 32'h80000000, 1'b0);

    // rounding and special operands on the x lane
    for (int i = 0; i < 8; i++) begin
      send(rv_a[i], 32'h0, FP32_ONE, rv_b[i]);
      wait_out();
      chk("round_ox", ox, rv_exp[i]);
      chk("round_ovf", 32'(out_ovf), 32'd0);
    end

    // reset while in MUL_Y, then a clean transaction
    send(32'h3F000000, 32'hBF000000, 32'h3E800000, 32'h40800000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    expect_out("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    send(32'h3F000000, 32'hBF000000, 32'h3E800000, 32'h40800000);
    wait_out();
    expect_out("post_rst", 32'h40000000, 32'hC0000000, 32'h3F800000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
